sdram_port_arb: RTL and testbench
=================================

# sdram_port_arb

Two-requester arbiter and sequencer for the single SDRAM controller command port, clocked in the `sdram_clk` domain. Requester 0 is the USB write path (the `wr_valid/wr_ready/wr_addr/wr_data` stream produced from the CY68013 FIFO). Requester 1 is a read-back path (QSPI/USB upload). The block grants the port in bounded bursts with round-robin fairness and a one-cycle turnaround between directions. It limits in-flight reads, holds everything off until `sdram_init_done`, and routes read data back to requester 1.

## Interface
- `BURST_MAX`, 16: maximum accepted commands per grant (2..256).
- `RD_OUTST_MAX`, 4: maximum reads issued but not yet returned (1..15).
- `AW`, 24: address width.
- `DW`, 16: data width.

Ports:
- `sdram_clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `sdram_init_done` in 1: SDRAM controller init complete.
- `wr_valid` in 1: requester 0 write request.
- `wr_ready` out 1: requester 0 accept.
- `wr_addr` in AW: write address.
- `wr_data` in DW: write data.
- `rd_req_valid` in 1: requester 1 read request.
- `rd_req_ready` out 1: requester 1 accept.
- `rd_addr` in AW: read address.
- `rd_data` out DW: read data to requester 1.
- `rd_data_valid` out 1: read data strobe.
- `cmd_valid` out 1: command to the SDRAM controller.
- `cmd_ready` in 1: controller accepts the command.
- `cmd_wr` out 1: 1 = write, 0 = read.
- `cmd_addr` out AW: command address.
- `cmd_wdata` out DW: write data.
- `sdram_rdata` in DW: controller read data.
- `sdram_rdata_valid` in 1: controller read data strobe.
- `err_unexp_rdata` out 1: sticky flag, read data arrived with no read outstanding.
- `wr_cmd_cnt` out 32: accepted write commands (see Configuration).
- `rd_cmd_cnt` out 32: accepted read commands (see Configuration).

## Operation
- State machine has states INIT, ARB, WR_GNT, RD_GNT and TURN. The state, `last_gnt`, `burst_cnt` and `outst` are all registered.
- **INIT:** all ready and valid outputs are 0. Move to ARB on the cycle after `sdram_init_done` is sampled at 1.
- **ARB:** choose a direction from the inputs sampled this cycle.
  - Read is eligible when `rd_req_valid` is 1 and `outst` < `RD_OUTST_MAX`.
  - If both the write request and an eligible read are present, grant the opposite of `last_gnt`.
  - Otherwise grant the single requester that is present; with no requester, stay in ARB.
  - On grant, set `last_gnt` and clear `burst_cnt`.
- **WR_GNT (command mux, combinational):** `cmd_valid` = `wr_valid`, `cmd_wr` = 1, `cmd_addr` = `wr_addr`, `cmd_wdata` = `wr_data`, `wr_ready` = `cmd_ready`. `rd_req_ready` = 0.
- **RD_GNT (command mux, combinational):**
  - `cmd_valid` = `rd_req_valid` & (`outst` < `RD_OUTST_MAX`), and `cmd_wr` = 0.
  - `rd_req_ready` = `cmd_ready` & (`outst` < `RD_OUTST_MAX`).
  - `cmd_wdata` = 0 and `wr_ready` = 0.
- **Handshake:** a handshake is `cmd_valid` & `cmd_ready`. Each handshake increments `burst_cnt`.
- **Release a grant** (go to TURN) when either:
  - a handshake occurs with `burst_cnt` == `BURST_MAX`-1; or
  - the granted requester is not valid (or, in RD_GNT, is blocked by `outst`) while the other requester is present.
- **Parking:** with no competing request, the grant is held indefinitely and `burst_cnt` saturates at `BURST_MAX`-1. It then releases immediately once the other side appears.
- **TURN:** one bubble cycle with `cmd_valid` = 0, then return to ARB.
- **Outstanding reads:** `outst` increments on a read handshake and decrements on `sdram_rdata_valid`. When both happen in the same cycle, it is unchanged.
- **Unexpected read data:** `sdram_rdata_valid` with `outst` == 0 sets `err_unexp_rdata`, and `outst` stays 0. Only `rst` clears the flag.
- **Read data return:** `rd_data` = `sdram_rdata` and `rd_data_valid` = `sdram_rdata_valid`, both pass-through. Return order equals issue order.
- **Init loss:** if `sdram_init_done` falls in any state, `cmd_valid`, `wr_ready` and `rd_req_ready` go to 0 in the same cycle (combinational gate), and the next state is INIT. `outst` is kept, so pending reads still return.

## Timing
- **Reset:** all outputs 0. State is INIT, `last_gnt` = RD (so writes win the first tie), `burst_cnt` = 0, `outst` = 0, and counters are 0.
- **Latency:** request to command is 0 cycles once granted (pure mux). Gaining a grant costs 1 cycle from ARB. A direction switch costs 2 dead cycles (TURN + ARB).
- **Handshake rule:** a requester must hold valid, address and data stable until it sees ready.
- **Burst bound:** in a single grant, at most `BURST_MAX` handshakes occur, back to back at 1 per cycle.
- **Read data:** read data timing is set by the controller. `rd_data_valid` has the same-cycle relation to `sdram_rdata_valid`.

## Configuration
- Macro `SDRAM_ARB_STATS_EN`.
- **Defined:** `wr_cmd_cnt` and `rd_cmd_cnt` increment on each write or read handshake respectively. They saturate at 0xFFFFFFFF and are cleared by `rst`.
- **Undefined:** both outputs are tied to 0 and no counter flops are built.

## Test plan
- **Init gating:** hold `wr_valid`=1 with `sdram_init_done`=0 for 20 cycles, so `cmd_valid` stays 0. Raise init; the first write handshake must occur exactly 2 cycles later (INIT→ARB→WR_GNT), given `cmd_ready`=1.
- **Write burst bound:** use `BURST_MAX`=16 with 40 queued writes and `rd_req_valid`=1 throughout. Expect exactly 16 consecutive write commands, 2 idle cycles, then reads, alternating in bursts of ≤16.
- **Outstanding limit:** use `RD_OUTST_MAX`=4 with `sdram_rdata_valid` withheld. Exactly 4 read handshakes occur and `rd_req_ready` then stays 0. One `sdram_rdata_valid` pulse allows exactly one more read.
- **Simultaneous issue and return:** a read handshake and `sdram_rdata_valid` in the same cycle at `outst`=2 leave `outst`=2. A stray `sdram_rdata_valid` at `outst`=0 sets `err_unexp_rdata`=1 and it persists.
- **Init loss mid-burst:** deassert `sdram_init_done` during the 5th write of a burst. `cmd_valid` is 0 in that same cycle; the state returns to INIT, and writes resume with a fresh grant after re-init.
- **Stats:** with `SDRAM_ARB_STATS_EN` defined, 100 writes and 37 reads give `wr_cmd_cnt`=100 and `rd_cmd_cnt`=37. With the macro undefined, both read 0.

Source files
------------

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: burst-bounded round-robin arbiter for the SDRAM command port
// Define SDRAM_ARB_STATS_EN to build the saturating write/read command counters.
module sdram_port_arb #(
  parameter int BURST_MAX = 16,
  parameter int RD_OUTST_MAX = 4,
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic          sdram_clk,
  input  logic          rst,
  input  logic          sdram_init_done,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_data_valid,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_wr,
  output logic [AW-1:0] cmd_addr,
  output logic [DW-1:0] cmd_wdata,
  input  logic [DW-1:0] sdram_rdata,
  input  logic          sdram_rdata_valid,
  output logic          err_unexp_rdata,
  output logic [31:0]   wr_cmd_cnt,
  output logic [31:0]   rd_cmd_cnt
);
  localparam int BW = $clog2(BURST_MAX);
  localparam int OW = $clog2(RD_OUTST_MAX + 1);
  typedef enum logic [2:0] {INIT, ARB, WR_GNT, RD_GNT, TURN} state_t;
  state_t state_q;
  logic last_rd_q, err_q;
  logic [BW-1:0] burst_q;
  logic [OW-1:0] outst_q, outst_d;
  logic wr_g, rd_g, rd_ok, rd_elig, hs, at_max, rel, pick_rd;
  always_comb begin
    wr_g = state_q == WR_GNT;
    rd_g = state_q == RD_GNT;
    rd_ok = outst_q < OW'(RD_OUTST_MAX);
    rd_elig = rd_req_valid & rd_ok;
    cmd_valid = sdram_init_done & (wr_g ? wr_valid : rd_g & rd_elig);
    cmd_wr = wr_g;
    cmd_addr = wr_g ? wr_addr : rd_g ? rd_addr : '0;
    cmd_wdata = wr_g ? wr_data : '0;
    wr_ready = sdram_init_done & wr_g & cmd_ready;
    rd_req_ready = sdram_init_done & rd_g & cmd_ready & rd_ok;
    hs = cmd_valid & cmd_ready;
    at_max = burst_q == BW'(BURST_MAX - 1);
    // release only when the other side wants the port; otherwise the grant parks
    rel = (wr_g ? rd_elig : wr_valid) & ((wr_g ? !wr_valid : !rd_elig) | (hs & at_max));
    pick_rd = rd_elig & (!wr_valid | !last_rd_q);
    outst_d = outst_q + OW'(hs & rd_g) - OW'(sdram_rdata_valid && outst_q != '0);
  end
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      state_q <= INIT;
      last_rd_q <= 1'b1;
      burst_q <= '0;
      outst_q <= '0;
      err_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (sdram_rdata_valid && outst_q == '0) err_q <= 1'b1;
      if (!sdram_init_done) state_q <= INIT;
      else case (state_q)
        INIT: state_q <= ARB;
        ARB: if (wr_valid || rd_elig) begin
          state_q <= pick_rd ? RD_GNT : WR_GNT;
          last_rd_q <= pick_rd;
          burst_q <= '0;
        end
        WR_GNT, RD_GNT: begin
          if (rel) state_q <= TURN;
          if (hs && !at_max) burst_q <= burst_q + BW'(1);
        end
        default: state_q <= ARB;
      endcase
    end
  end
  assign rd_data = sdram_rdata;
  assign rd_data_valid = sdram_rdata_valid;
  assign err_unexp_rdata = err_q;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (hs && wr_g && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (hs && rd_g && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end
  assign wr_cmd_cnt = wr_cnt_q;
  assign rd_cmd_cnt = rd_cnt_q;
`else
  assign wr_cmd_cnt = '0;
  assign rd_cmd_cnt = '0;
`endif
endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed and randomized checks of sdram_port_arb against a transaction-level model
module tb_sdram_port_arb;
  localparam int BM = 16, OM = 4, AW = 24, DW = 16;
  logic clk = 1'b0, rst, init, wr_valid, rd_req_valid, cmd_ready, sdram_rdata_valid;
  logic [AW-1:0] wr_addr, rd_addr, cmd_addr;
  logic [DW-1:0] wr_data, sdram_rdata, rd_data, cmd_wdata;
  logic wr_ready, rd_req_ready, rd_data_valid, cmd_valid, cmd_wr, err_unexp_rdata;
  logic [31:0] wr_cmd_cnt, rd_cmd_cnt;
  sdram_port_arb #(.BURST_MAX(BM), .RD_OUTST_MAX(OM), .AW(AW), .DW(DW)) dut (
    .sdram_clk(clk), .rst(rst), .sdram_init_done(init),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .sdram_rdata(sdram_rdata), .sdram_rdata_valid(sdram_rdata_valid),
    .err_unexp_rdata(err_unexp_rdata), .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int m_outst, m_wr, m_rd, cyc = 0, mcyc, hs_code, last_dir, last_hs_cyc;
  int rd_left, gap_w, gap_r, ret_mode, init_off;
  bit m_err, rnd, rdy_rnd, rdv_s, mv;
  logic [AW-1:0] rd_next;
  logic [AW+DW-1:0] wq[$];
  int lg[$], e[$];
  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mon();
    bit hw, hr;
    int d;
    mcyc = cyc;
    hw = cmd_valid & cmd_ready & cmd_wr;
    hr = cmd_valid & cmd_ready & !cmd_wr;
    if (!init) cmp("init_gate", {cmd_valid, wr_ready, rd_req_ready}, 0);
    if (m_outst >= OM) cmp("outst_block", {rd_req_ready, cmd_valid & !cmd_wr}, 0);
    if (cmd_valid & cmd_wr) begin
      cmp("wr_cmd_valid", wr_valid, 1);
      if (wq.size() > 0) cmp("wr_cmd_fields", {cmd_addr, cmd_wdata}, wq[0]);
    end
    if (cmd_valid & !cmd_wr) cmp("rd_cmd_fields", {rd_req_valid, cmd_addr, cmd_wdata}, {1'b1, rd_next, {DW{1'b0}}});
    cmp("wr_handshake", wr_ready & wr_valid, hw);
    cmp("rd_handshake", rd_req_ready & rd_req_valid, hr);
    cmp("both_ready", wr_ready & rd_req_ready, 0);
    cmp("rdata_pass", {rd_data_valid, rd_data}, {sdram_rdata_valid, sdram_rdata});
    cmp("err_flag", err_unexp_rdata, m_err);
`ifdef SDRAM_ARB_STATS_EN
    cmp("cnt_live", {wr_cmd_cnt, rd_cmd_cnt}, {m_wr, m_rd});
`else
    cmp("cnt_live", {wr_cmd_cnt, rd_cmd_cnt}, 0);
`endif
    if (hw | hr) begin
      d = hw ? 1 : 2;
      if (last_dir != 0 && d != last_dir) cmp("turnaround", mcyc - last_hs_cyc >= 3, 1);
      last_dir = d;
      last_hs_cyc = mcyc;
    end
    hs_code = hw ? 1 : hr ? 2 : 0;
    rdv_s = sdram_rdata_valid;
    mv = cmd_valid;
  endtask
  task automatic upd();
    if (gap_w > 0) gap_w--;
    if (gap_r > 0) gap_r--;
    if (hs_code == 1) begin
      void'(wq.pop_front());
      gap_w = rnd ? int'($urandom_range(0, 2)) : 0;
    end
    if (hs_code == 2) begin
      rd_left--;
      rd_next = rd_next + AW'(1);
      gap_r = rnd ? int'($urandom_range(0, 2)) : 0;
    end
    if (rst) begin
      m_outst = 0; m_err = 0; m_wr = 0; m_rd = 0; last_dir = 0;
    end else begin
      if (hs_code == 1) m_wr++;
      if (rdv_s) begin
        if (m_outst == 0) m_err = 1;
        else m_outst--;
      end
      if (hs_code == 2) begin
        m_rd++;
        m_outst++;
      end
    end
    cyc++;
  endtask
  task automatic drive();
    wr_valid = wq.size() > 0 && gap_w == 0;
    if (wq.size() > 0) {wr_addr, wr_data} = wq[0];
    else {wr_addr, wr_data} = {AW'($urandom), DW'($urandom)};
    rd_req_valid = rd_left > 0 && gap_r == 0;
    rd_addr = rd_next;
    cmd_ready = rdy_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    sdram_rdata_valid = m_outst > 0 && (ret_mode == 1 || (ret_mode == 2 && $urandom_range(0, 2) == 0));
    sdram_rdata = DW'($urandom);
  endtask
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    upd();
    #1;
    drive();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    wq.delete();
    rd_left = 0; gap_w = 0; gap_r = 0;
    drive();
    step();
    step();
    rst = 1'b0;
    drive();
  endtask
  task automatic push_w(input int n);
    repeat (n) wq.push_back({AW'($urandom), DW'($urandom)});
  endtask
  task automatic first_wr(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      step();
      if (hs_code == 1) lat = mcyc - t0;
    end
  endtask
  initial begin
    int lat, t0, w, r, dir, own, oth, n;
    rst = 1'b1; init = 1'b0; rnd = 0; rdy_rnd = 0; ret_mode = 0; init_off = 0;
    m_outst = 0; m_err = 0; m_wr = 0; m_rd = 0; last_dir = 0; last_hs_cyc = 0;
    rd_left = 0; gap_w = 0; gap_r = 0; hs_code = 0; rdv_s = 0;
    rd_next = AW'($urandom);
    drive();
    do_reset();
    push_w(30);
    drive();
    #1;
    cmp("rst_cmd", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, 0);
    cmp("rst_ready", {wr_ready, rd_req_ready}, 0);
    cmp("rst_err", err_unexp_rdata, 0);
    cmp("rst_cnt", {wr_cmd_cnt, rd_cmd_cnt}, 0);
    repeat (20) step();
    cmp("init_hold", m_wr, 0);
    init = 1'b1;
    t0 = cyc;
    first_wr(t0, lat);
    cmp("init_latency", lat, 2);
    do_reset();
    push_w(40);
    rd_left = 40;
    ret_mode = 1;
    drive();
    lg.delete();
    repeat (160) begin
      step();
      lg.push_back(hs_code);
    end
    e.delete();
    e.push_back(0);
    e.push_back(0);
    w = 40; r = 40; dir = 1;
    while (w + r > 0) begin
      own = dir == 1 ? w : r;
      n = own < BM ? own : BM;
      repeat (n) e.push_back(dir);
      if (dir == 1) w -= n;
      else r -= n;
      own -= n;
      oth = dir == 1 ? r : w;
      if (oth > 0) begin
        repeat (n == BM ? 2 : 3) e.push_back(0);
        dir = 3 - dir;
      end else if (own == 0) break;
    end
    for (int i = 0; i < e.size(); i++) cmp($sformatf("burst_seq[%0d]", i), lg[i], e[i]);
    cmp("burst_totals", {m_wr, m_rd}, {32'd40, 32'd40});
    do_reset();
    ret_mode = 0;
    rd_left = 10;
    drive();
    repeat (20) step();
    cmp("outst_limit", m_rd, OM);
    sdram_rdata_valid = 1'b1;
    step();
    repeat (10) step();
    cmp("outst_one_more", m_rd, OM + 1);
    do_reset();
    rd_left = 2;
    drive();
    repeat (10) step();
    cmp("simul_pre", m_rd, 2);
    rd_left = 1;
    drive();
    sdram_rdata_valid = 1'b1;
    step();
    cmp("simul_hs", hs_code, 2);
    rd_left = 5;
    drive();
    repeat (15) step();
    cmp("simul_limit", m_rd, 5);
    do_reset();
    sdram_rdata_valid = 1'b1;
    step();
    cmp("stray_set", err_unexp_rdata, 1);
    repeat (5) step();
    cmp("stray_sticky", err_unexp_rdata, 1);
    do_reset();
    cmp("stray_cleared", err_unexp_rdata, 0);
    push_w(20);
    drive();
    for (int i = 0; i < 20 && m_wr < 4; i++) step();
    cmp("loss_pre", m_wr, 4);
    init = 1'b0;
    step();
    cmp("loss_gate", mv, 0);
    repeat (3) step();
    cmp("loss_hold", m_wr, 4);
    init = 1'b1;
    t0 = cyc;
    first_wr(t0, lat);
    cmp("reinit_latency", lat, 2);
    do_reset();
    rnd = 1; rdy_rnd = 1; ret_mode = 1;
    push_w(100);
    rd_left = 37;
    drive();
    for (int i = 0; i < 3000 && (wq.size() > 0 || rd_left > 0); i++) step();
    cmp("stats_done", {wq.size() == 0, rd_left == 0}, 2'b11);
`ifdef SDRAM_ARB_STATS_EN
    cmp("stats_wr", wr_cmd_cnt, 100);
    cmp("stats_rd", rd_cmd_cnt, 37);
`else
    cmp("stats_wr", wr_cmd_cnt, 0);
    cmp("stats_rd", rd_cmd_cnt, 0);
`endif
    do_reset();
    ret_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (wq.size() < 3 && $urandom_range(0, 2) == 0) push_w(1);
      if (rd_left < 3 && $urandom_range(0, 3) == 0) rd_left++;
      if (init_off > 0) begin
        init = 1'b0;
        init_off--;
      end else begin
        init = 1'b1;
        if ($urandom_range(0, 199) == 0) init_off = int'($urandom_range(1, 5));
      end
      drive();
      step();
    end
    init = 1'b1;
    ret_mode = 1;
    for (int i = 0; i < 500 && (wq.size() > 0 || rd_left > 0); i++) step();
    cmp("rand_drain", {wq.size() == 0, rd_left == 0}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
